// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide issue controller.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE    = 32'hFFFF_FFFF;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Resolves the RISC-V divide corner cases (x/0 and INT_MIN/-1) without the divider.
module div_special_case
    import div_pkg::*;
(
    input  div_op_e     op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        is_special,
    output logic [31:0] special_result
);

    // Corner-case detection and the architecturally defined result
    always_comb begin
        is_special     = 1'b0;
        special_result = 32'h0000_0000;
        if (rs2 == 32'h0000_0000) begin
            is_special     = 1'b1;
            special_result = op_is_rem(op) ? rs1 : DIV_ZERO_Q;
        end else if (op_is_signed(op) && (rs1 == INT_MIN) && (rs2 == NEG_ONE)) begin
            is_special     = 1'b1;
            special_result = op_is_rem(op) ? 32'h0000_0000 : INT_MIN;
        end else begin
            is_special     = 1'b0;
            special_result = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller between execute and the iterative divider: accepts one request,
// resolves corner cases locally, otherwise sequences the divider and returns a tagged result.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int MAX_CYCLES = 64,
    parameter int TAG_W      = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    output logic             div_signed_a,
    output logic             div_signed_b,
    output logic             div_enable,
    input  logic [31:0]      div_quotient,
    input  logic [31:0]      div_remainder,
    input  logic             div_data_valid
);

    localparam int               CNT_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e        state_r, state_next_s;
    div_op_e           req_op_s, op_r;
    logic              special_s;
    logic [31:0]       special_result_s;
    logic              accept_s, capture_s, timeout_s;
    logic [CNT_W-1:0]  wdog_r;

    logic              req_ready_r, resp_valid_r, resp_err_r, div_enable_r;
    logic              div_signed_a_r, div_signed_b_r;
    logic [31:0]       resp_data_r, div_a_r, div_b_r;
    logic [TAG_W-1:0]  resp_tag_r;

    assign req_op_s = div_op_e'(req_op);

    div_special_case u_special (
        .op             (req_op_s),
        .rs1            (req_rs1),
        .rs2            (req_rs2),
        .is_special     (special_s),
        .special_result (special_result_s)
    );

    // Next-state and transaction strobes; flush outranks every other event
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = special_s ? ST_RESP : ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (div_data_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else if (wdog_r == CNT_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (flush || resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus handshake/enable flags registered from the next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            div_enable_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            req_ready_r  <= (state_next_s == ST_IDLE);
            resp_valid_r <= (state_next_s == ST_RESP);
            div_enable_r <= (state_next_s == ST_BUSY);
        end
    end

    // Watchdog: counts BUSY cycles, zero on every entry to BUSY
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_BUSY) begin
            wdog_r <= wdog_r + CNT_ONE;
        end else begin
            wdog_r <= {CNT_W{1'b0}};
        end
    end

    // Request capture, divider operands and response payload
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_r           <= OP_DIV;
            resp_tag_r     <= {TAG_W{1'b0}};
            resp_data_r    <= 32'h0000_0000;
            resp_err_r     <= 1'b0;
            div_a_r        <= 32'h0000_0000;
            div_b_r        <= 32'h0000_0000;
            div_signed_a_r <= 1'b0;
            div_signed_b_r <= 1'b0;
        end else if (accept_s) begin
            op_r       <= req_op_s;
            resp_tag_r <= req_tag;
            resp_err_r <= 1'b0;
            if (special_s) begin
                resp_data_r <= special_result_s;
            end else begin
                div_a_r        <= req_rs1;
                div_b_r        <= req_rs2;
                div_signed_a_r <= op_is_signed(req_op_s);
                div_signed_b_r <= op_is_signed(req_op_s);
            end
        end else if (capture_s) begin
            resp_data_r <= op_is_rem(op_r) ? div_remainder : div_quotient;
            resp_err_r  <= 1'b0;
        end else if (timeout_s) begin
            resp_data_r <= 32'h0000_0000;
            resp_err_r  <= 1'b1;
        end else begin
            resp_data_r <= resp_data_r;
            resp_err_r  <= resp_err_r;
        end
    end

    assign req_ready    = req_ready_r;
    assign resp_valid   = resp_valid_r;
    assign resp_data    = resp_data_r;
    assign resp_tag     = resp_tag_r;
    assign resp_err     = resp_err_r;
    assign div_a        = div_a_r;
    assign div_b        = div_b_r;
    assign div_signed_a = div_signed_a_r;
    assign div_signed_b = div_signed_b_r;
    assign div_enable   = div_enable_r;

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Initiator-side controller that sits between the execute stage and the iterative `divider`. It accepts RV32M DIV/DIVU/REM/REMU requests over a valid/ready handshake and resolves the RISC-V special cases (divide-by-zero, signed overflow) locally. All other requests are sequenced through the divider's enable/data_valid protocol, and each result is returned over a valid/ready response channel together with its destination tag.

## Interface
- `MAX_CYCLES`, default 64: watchdog limit, in cycles, on waiting for `div_data_valid`.
- `TAG_W`, default 5: width of the destination-register tag.
- `clock` in 1: sole clock; everything is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 2: operation; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_rs1` in 32: dividend.
- `req_rs2` in 32: divisor.
- `req_tag` in TAG_W: destination tag.
- `flush` in 1: synchronous kill of any in-flight request.
- `resp_valid` out 1: result present.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out 32: quotient or remainder, as selected by the op.
- `resp_tag` out TAG_W: echoes the request tag.
- `resp_err` out 1: watchdog expired; `resp_data` is 0.
- `div_a` out 32, `div_b` out 32: registered operands to the divider.
- `div_signed_a` out 1, `div_signed_b` out 1: both are high for DIV/REM and low for DIVU/REMU.
- `div_enable` out 1: held high while the divider owns the operation.
- `div_quotient` in 32, `div_remainder` in 32, `div_data_valid` in 1: divider results.

## Operation
- **Divider contract:** the operands must stay stable while `div_enable` is high. The divider clears `div_data_valid` whenever `div_enable` is low. The controller always leaves `div_enable` low for at least one cycle between operations.
- **States:** IDLE, BUSY, RESP.
- **IDLE:** `req_ready` = 1. On `req_valid`:
  - Latch op, operands and tag.
  - Evaluate the special cases combinationally on the request.
  - If a special case applies, register its result and go to RESP. The divider is not touched.
  - Otherwise register `div_a`/`div_b`/signed flags and go to BUSY.
- **Special cases:**
  - Divisor 0: the quotient is 0xFFFFFFFF for both DIV and DIVU; the remainder is rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): the quotient is 0x80000000 and the remainder is 0.
- **BUSY:**
  - `div_enable` = 1 and the watchdog counter increments.
  - On `div_data_valid`: capture the quotient (DIV/DIVU) or the remainder (REM/REMU) into `resp_data`, drop `div_enable`, and go to RESP.
  - If the counter reaches `MAX_CYCLES` first: `resp_err` = 1, `resp_data` = 0, go to RESP.
- **RESP:**
  - `resp_valid` = 1, with data, tag and err held stable.
  - On `resp_ready`, go to IDLE. No new request is accepted in that same cycle.
- **Flush:**
  - In any state, go to IDLE on the next edge with `div_enable` = 0; the pending response is discarded.
  - In IDLE, flush has priority over `req_valid`, and the request is not accepted.
- **Reset mid-operation:** immediate return to IDLE. A late divider `data_valid` after reset or flush is ignored, because it is only sampled in BUSY.

## Timing
- **Reset values:**
  - `req_ready` = 1.
  - `resp_valid`, `resp_err`, `div_enable`, `div_signed_a`, `div_signed_b` = 0.
  - `resp_data`, `div_a`, `div_b` = 0.
  - `resp_tag` = 0.
- **Special-case latency:** accept at edge N; `resp_valid` is high from N+1.
- **Normal latency:** accept at N, and `div_enable` rises at N+1. If `div_data_valid` is first seen at cycle M, `div_enable` is low and `resp_valid` high from M+1.
- **Throughput:** at most one request is in flight. After a response handshake, `req_ready` reasserts on the next cycle.
- **Backpressure:** `resp_valid` stays asserted indefinitely while `resp_ready` = 0, and the outputs do not change.
- **Watchdog:** the counter is 0 on entry to BUSY. The error response is issued on the cycle after `MAX_CYCLES` BUSY cycles without `div_data_valid`.

## Structure
- **Package `div_pkg`:**
  - Op enum (DIV, DIVU, REM, REMU).
  - State enum (IDLE, BUSY, RESP).
  - Constants `DIV_ZERO_Q` = 0xFFFFFFFF and `INT_MIN` = 0x80000000.
- **Sub-module `div_special_case`:** purely combinational. Takes op, rs1 and rs2; returns `is_special` and `special_result`.
- **Top level:** the FSM, operand/result registers, and the watchdog counter.

## Test plan
- DIVU 15634654 / 21354 with a real divider -> `resp_data` = 732, with `div_enable` high only during BUSY. REMU with the same operands -> 3526.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD (−3). REM with the same operands -> 0xFFFFFFFF (−1). `div_signed_a`/`div_signed_b` are both 1.
- Divide-by-zero:
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REM 5 / 0 -> 5.
  - `resp_valid` is asserted one cycle after accept, and `div_enable` never rises.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM with the same operands -> 0. Both complete in one cycle with no divider activity.
- Backpressure and tag: hold `resp_ready` = 0 for 10 cycles with tag 0x13. `resp_valid`, `resp_data` and `resp_tag` = 0x13 stay stable, and `req_ready` = 0 throughout.
- Flush and reset:
  - Flush in BUSY drops `div_enable` on the next edge and produces no response. A subsequent `data_valid` is ignored, and the next request completes correctly.
  - Asserting `reset_n` low mid-BUSY clears all outputs immediately.
  - A stalled divider triggers `resp_err` after 64 cycles.
